// File: rtl/pc_fetch_unit.sv
// IF-stage program counter: sequential fetch, branch/flush redirects, and a
// one-entry buffer that holds a branch target resolved while the pipe is stalled.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc,
  output logic        rom_en,
  output logic        pc_adel,
  output logic        redirect_pend
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        rom_en_q, adel_q;
  logic        misalign_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q + PC_STEP;
    pend_d  = pend_q;
    if (flush) begin
      pc_d    = flush_pc;
      state_d = RUN;
    end else if (stall_pc) begin
      pc_d = pc_q;
      if (branch_flag) begin
        // Later targets during the same stall overwrite earlier ones.
        pend_d  = branch_addr;
        state_d = HOLD;
      end
    end else if (branch_flag) begin
      pc_d    = branch_addr;
      state_d = RUN;
    end else if (state_q == HOLD) begin
      pc_d    = pend_q;
      state_d = RUN;
    end
  end

  assign misalign_d = |pc_d[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      pend_q   <= '0;
      rom_en_q <= 1'b0;
      adel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      rom_en_q <= !misalign_d;
      adel_q   <= misalign_d;
    end
  end

  assign pc            = pc_q;
  assign rom_en        = rom_en_q;
  assign pc_adel       = adel_q;
  assign redirect_pend = (state_q == HOLD);

endmodule
